dma_axi_wr_master: RTL and testbench

AXI4 write master for the DMA datapath. It accepts one transfer command (start address and beat count) and a beat stream from the DMA data buffer. It splits the transfer into INCR bursts that never cross a 4 KB boundary, and drives the AW/W/B channels of a downstream AXI slave such as the memory model or the interconnect. It reports completion and any error response.

---
 rtl/amba_axi_pkg.sv | 15 +
 rtl/dma_pkg.sv | 19 +
 rtl/dma_burst_len_calc.sv | 38 +++
 rtl/dma_axi_wr_master.sv | 189 ++++++++++++++++++
 tb/tb_dma_axi_wr_master.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amba_axi_pkg.sv
// Shared AXI4 encodings: response type and burst-type constants.
package amba_axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_OKAY   = 2'b00;
  localparam axi_resp_t AXI_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_SLVERR = 2'b10;
  localparam axi_resp_t AXI_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/dma_pkg.sv
// DMA-wide definitions: write-master FSM states, 4 KB boundary, bytes-per-beat helper.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWData,
    StResp,
    StFin
  } wr_state_t;

  localparam int unsigned BOUNDARY_4K = 4096;

  // log2 of the number of bytes in one data beat (the AXI AxSIZE value).
  function automatic int unsigned log2_bytes(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dma_burst_len_calc.sv
// Burst length calculator for the DMA write master.
// Ports:
//   cur_addr  in   burst start byte address (beat aligned)
//   rem       in   beats still to be written
//   blen      out  beats in this burst = min(rem, MAX_BURST, beats left in the 4 KB page)
module dma_burst_len_calc
  import dma_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic [AXI_ADDR_W-1:0] cur_addr,
  input  logic [CNT_W-1:0]      rem,
  output logic [8:0]            blen
);

  localparam int unsigned SizeLog2 = log2_bytes(AXI_DATA_W);

  logic [12:0] room_bytes;
  logic [12:0] room_beats;
  logic [31:0] lim;

  // Only the page offset matters for the boundary.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cur_addr[AXI_ADDR_W-1:12];

  always_comb begin
    room_bytes = 13'(BOUNDARY_4K) - {1'b0, cur_addr[11:0]};
    room_beats = room_bytes >> SizeLog2;
    lim        = 32'(MAX_BURST);
    if (32'(room_beats) < lim) lim = 32'(room_beats);
    if (32'(rem) < lim) lim = 32'(rem);
    blen = 9'(lim);
  end

endmodule

// File: rtl/dma_axi_wr_master.sv
// AXI4 write master for the DMA datapath. Takes one command (start address, beat count),
// splits it into INCR bursts that never cross 4 KB, and streams source beats straight onto W.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   cmd_valid/ready/addr/beats     transfer command (accepted only when idle)
//   s_valid/s_data/s_ready         source beat stream (passed through, no storage)
//   aw*/w*/b*                      AXI4 write address/data/response channels
//   busy, done, err                in-progress flag, one-cycle completion pulse, sticky error
module dma_axi_wr_master
  import amba_axi_pkg::*;
  import dma_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned WR_ID      = 0,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [CNT_W-1:0]        cmd_beats,
  input  logic                    s_valid,
  input  logic [AXI_DATA_W-1:0]   s_data,
  output logic                    s_ready,
  output logic [AXI_ID_W-1:0]     awid,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [AXI_ID_W-1:0]     bid,
  input  axi_resp_t               bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned SizeLog2 = log2_bytes(AXI_DATA_W);
  localparam logic [AXI_ADDR_W-1:0] AlignMask = AXI_ADDR_W'((1 << SizeLog2) - 1);

  wr_state_t               state_q, state_d;
  logic [AXI_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              bcnt_q, bcnt_d;
  logic                    err_q, err_d;

  logic [8:0]              blen_cur;
  logic [AXI_ADDR_W-1:0]   addr_after;
  logic [CNT_W-1:0]        rem_after;
  logic [AXI_ADDR_W-1:0]   calc_addr;
  logic [CNT_W-1:0]        calc_rem;
  logic [8:0]              calc_blen;

  logic unused_bid;
  assign unused_bid = ^bid;

  // Position after the burst in flight; only meaningful once its B response arrives.
  assign blen_cur   = {1'b0, awlen_q} + 9'd1;
  assign addr_after = cur_addr_q + (AXI_ADDR_W'(blen_cur) << SizeLog2);
  assign rem_after  = rem_q - CNT_W'(blen_cur);

  // The calculator sees the command when idle, otherwise the post-burst position.
  always_comb begin
    if (state_q == StIdle) begin
      calc_addr = cmd_addr & ~AlignMask;
      calc_rem  = cmd_beats;
    end else begin
      calc_addr = addr_after;
      calc_rem  = rem_after;
    end
  end

  dma_burst_len_calc #(
    .AXI_ADDR_W (AXI_ADDR_W),
    .AXI_DATA_W (AXI_DATA_W),
    .MAX_BURST  (MAX_BURST),
    .CNT_W      (CNT_W)
  ) u_burst_len_calc (
    .cur_addr (calc_addr),
    .rem      (calc_rem),
    .blen     (calc_blen)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    awlen_d    = awlen_q;
    bcnt_d     = bcnt_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cur_addr_d = calc_addr;
          rem_d      = calc_rem;
          err_d      = 1'b0;
          if (cmd_beats == '0) begin
            state_d = StFin;
          end else begin
            awlen_d = 8'(calc_blen - 9'd1);
            bcnt_d  = '0;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (awready) state_d = StWData;
      end
      StWData: begin
        if (wvalid && wready) begin
          bcnt_d = bcnt_q + 8'd1;
          if (wlast) begin
            bcnt_d  = '0;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (bvalid) begin
          if (bresp != AXI_OKAY) err_d = 1'b1;
          cur_addr_d = addr_after;
          rem_d      = rem_after;
          if (rem_after == '0) begin
            state_d = StFin;
          end else begin
            awlen_d = 8'(calc_blen - 9'd1);
            state_d = StAddr;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      rem_q      <= '0;
      awlen_q    <= '0;
      bcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      awlen_q    <= awlen_d;
      bcnt_q     <= bcnt_d;
      err_q      <= err_d;
    end
  end

  // All handshake outputs decode from state so reset drops them in the same cycle.
  assign cmd_ready = (state_q == StIdle);
  assign awid      = AXI_ID_W'(WR_ID);
  assign awaddr    = cur_addr_q;
  assign awlen     = awlen_q;
  assign awsize    = 3'(SizeLog2);
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = (state_q == StAddr);
  assign wdata     = s_data;
  assign wstrb     = '1;
  assign wvalid    = (state_q == StWData) && s_valid;
  assign wlast     = (state_q == StWData) && (bcnt_q == awlen_q);
  assign s_ready   = (state_q == StWData) && wready;
  assign bready    = (state_q == StResp);
  assign busy      = (state_q == StAddr) || (state_q == StWData) || (state_q == StResp);
  assign done      = (state_q == StFin);
  assign err       = err_q;

endmodule

// File: tb/tb_dma_axi_wr_master.sv
// Directed bench for dma_axi_wr_master with a cycle-level AXI slave / source model.
module tb_dma_axi_wr_master;
  import amba_axi_pkg::*;

  localparam logic [31:0] DataBase = 32'hD000_0000;

  logic        clk, resetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  axi_resp_t   bresp;
  logic        bvalid, bready;
  logic        busy, done, err;

  dma_axi_wr_master u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave / source model state.
  bit          rand_mode = 1'b0;
  int          err_burst = -1;
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [31:0] mem[logic [31:0]];
  int          w_burst, w_beat, b_pending, b_idx, src_idx, done_cnt;
  int          aw_unstable, w_early, wlast_err;
  logic        err_at_done;
  bit          aw_hold;
  logic [31:0] aw_hold_addr;
  logic [7:0]  aw_hold_len;
  logic        busy_after_accept, err_after_accept, done_after_accept;

  task automatic reset_sb();
    aw_addr_log.delete();
    aw_len_log.delete();
    mem.delete();
    w_burst = 0; w_beat = 0; b_pending = 0; b_idx = 0; src_idx = 0; done_cnt = 0;
    aw_unstable = 0; w_early = 0; wlast_err = 0; err_at_done = 1'bx; aw_hold = 1'b0;
  endtask

  function automatic logic [31:0] aw_addr_at(input int i);
    return (aw_addr_log.size() > i) ? aw_addr_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] aw_len_at(input int i);
    return (aw_len_log.size() > i) ? aw_len_log[i] : 8'hEE;
  endfunction

  // Drive at the falling edge, sample 1 time unit later; handshakes complete at the next rise.
  initial begin
    logic [31:0] a;
    bit          exp_last;
    awready = 1'b0; wready = 1'b0; s_valid = 1'b0; s_data = '0;
    bvalid = 1'b0; bresp = AXI_OKAY; bid = '0;
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        s_valid = 1'($urandom_range(0, 1));
      end else begin
        awready = 1'b1; wready = 1'b1; s_valid = 1'b1;
      end
      bvalid = (b_pending > 0) && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      bresp  = (b_idx == err_burst) ? AXI_SLVERR : AXI_OKAY;
      s_data = DataBase + 32'(src_idx);
      #1;
      if (resetn) begin
        if (aw_hold && (!awvalid || awaddr !== aw_hold_addr || awlen !== aw_hold_len))
          aw_unstable++;
        aw_hold      = awvalid && !awready;
        aw_hold_addr = awaddr;
        aw_hold_len  = awlen;
        if (awvalid && awready) begin
          aw_addr_log.push_back(awaddr);
          aw_len_log.push_back(awlen);
        end
        if (wvalid && wready) begin
          if (w_burst >= aw_addr_log.size()) begin
            w_early++;
          end else begin
            a = aw_addr_log[w_burst] + 32'(w_beat * 4);
            mem[a] = wdata;
            exp_last = (w_beat == int'(aw_len_log[w_burst]));
            if (wlast !== exp_last) wlast_err++;
            if (exp_last) begin
              w_burst++; w_beat = 0; b_pending++;
            end else begin
              w_beat++;
            end
          end
          src_idx++;
        end
        if (bvalid && bready) begin
          b_pending--;
          b_idx++;
        end
        if (done) begin
          done_cnt++;
          err_at_done = err;
        end
      end else begin
        aw_hold = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] n);
    int cyc;
    @(negedge clk);
    reset_sb();
    cmd_addr = a; cmd_beats = n; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    busy_after_accept = busy;
    err_after_accept  = err;
    done_after_accept = done;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] k;
      k = base + 32'(i * 4);
      if (!mem.exists(k)) bad++;
      else if (mem[k] !== DataBase + 32'(i)) bad++;
    end
    check_eq({tag, "_data"}, 64'(bad), 64'd0);
    check_eq({tag, "_nbeats"}, 64'(src_idx), 64'(n));
  endtask

  initial begin
    int  cyc;
    bit  saw_w;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    reset_sb();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_wlast", wlast, 0);
    check_eq("rst_bready", bready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_awaddr", awaddr, 0);
    check_eq("rst_awlen", awlen, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("const_awid", awid, 0);
    check_eq("const_awsize", awsize, 2);
    check_eq("const_awburst", awburst, 1);
    check_eq("const_wstrb", wstrb, 4'hF);
    @(negedge clk);
    resetn = 1'b1;

    // Single burst.
    run_cmd(32'h100, 16'd4);
    check_eq("single_busy", busy_after_accept, 1);
    check_eq("single_naw", aw_addr_log.size(), 1);
    check_eq("single_awaddr", aw_addr_at(0), 32'h100);
    check_eq("single_awlen", aw_len_at(0), 3);
    check_eq("single_wlast", wlast_err, 0);
    check_eq("single_done", done_cnt, 1);
    check_eq("single_err", err_at_done, 0);
    check_mem("single", 32'h100, 4);

    // Split into MAX_BURST pieces.
    run_cmd(32'h0, 16'd40);
    check_eq("split_naw", aw_addr_log.size(), 3);
    check_eq("split_addr0", aw_addr_at(0), 32'h0);
    check_eq("split_addr1", aw_addr_at(1), 32'h40);
    check_eq("split_addr2", aw_addr_at(2), 32'h80);
    check_eq("split_len0", aw_len_at(0), 15);
    check_eq("split_len1", aw_len_at(1), 15);
    check_eq("split_len2", aw_len_at(2), 7);
    check_eq("split_done", done_cnt, 1);
    check_mem("split", 32'h0, 40);

    // 4 KB boundary.
    run_cmd(32'hFF8, 16'd6);
    check_eq("b4k_naw", aw_addr_log.size(), 2);
    check_eq("b4k_addr0", aw_addr_at(0), 32'hFF8);
    check_eq("b4k_len0", aw_len_at(0), 1);
    check_eq("b4k_addr1", aw_addr_at(1), 32'h1000);
    check_eq("b4k_len1", aw_len_at(1), 3);
    check_eq("b4k_wlast", wlast_err, 0);
    check_mem("b4k", 32'hFF8, 6);

    // Random backpressure on every channel.
    rand_mode = 1'b1;
    run_cmd(32'h200, 16'd37);
    rand_mode = 1'b0;
    check_eq("bp_naw", aw_addr_log.size(), 3);
    check_eq("bp_addr2", aw_addr_at(2), 32'h280);
    check_eq("bp_len2", aw_len_at(2), 4);
    check_eq("bp_aw_stable", aw_unstable, 0);
    check_eq("bp_w_before_aw", w_early, 0);
    check_eq("bp_wlast", wlast_err, 0);
    check_eq("bp_done", done_cnt, 1);
    check_mem("bp", 32'h200, 37);

    // SLVERR on the second of three bursts.
    err_burst = 1;
    run_cmd(32'h400, 16'd48);
    err_burst = -1;
    check_eq("err_naw", aw_addr_log.size(), 3);
    check_eq("err_addr2", aw_addr_at(2), 32'h480);
    check_eq("err_at_done", err_at_done, 1);
    check_eq("err_done", done_cnt, 1);
    check_eq("err_sticky_idle", err, 1);
    run_cmd(32'h800, 16'd2);
    check_eq("err_clear_on_accept", err_after_accept, 0);
    check_eq("err_clear_at_done", err_at_done, 0);

    // Zero-length command.
    run_cmd(32'h500, 16'd0);
    check_eq("zero_done_next", done_after_accept, 1);
    check_eq("zero_busy", busy_after_accept, 0);
    check_eq("zero_naw", aw_addr_log.size(), 0);
    check_eq("zero_done_cnt", done_cnt, 1);

    // Reset in the middle of a data burst.
    @(negedge clk);
    reset_sb();
    cmd_addr = 32'h0; cmd_beats = 16'd16; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    saw_w = 1'b0;
    cyc = 0;
    while (!saw_w && cyc < 50) begin
      #1;
      if (wvalid) saw_w = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("rstmid_reached_w", saw_w, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("rstmid_awvalid", awvalid, 0);
    check_eq("rstmid_wvalid", wvalid, 0);
    check_eq("rstmid_wlast", wlast, 0);
    check_eq("rstmid_bready", bready, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_idle", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Recovery after reset.
    run_cmd(32'h300, 16'd2);
    check_eq("post_rst_naw", aw_addr_log.size(), 1);
    check_eq("post_rst_addr", aw_addr_at(0), 32'h300);
    check_eq("post_rst_len", aw_len_at(0), 1);
    check_eq("post_rst_done", done_cnt, 1);
    check_mem("post_rst", 32'h300, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
